// File: rtl/playback_pkg.sv
// ---------------------------------------------------------------------------
// playback_pkg
// Shared definitions for the playback sample engine:
//   - state_e      : playback FSM states
//   - ADDR_W_DEF   : default SRAM word address width
//   - DATA_W_DEF   : default sample width (signed two's complement)
//   - FRAC_W       : fractional bits of the reciprocal table
//   - PROD_W       : width used for the interpolation product and sum
//   - recip()      : floor(4096 / N) for N = ratio + 1 (1..8)
//   - sat16()      : saturate a wide signed value to 16-bit signed
// ---------------------------------------------------------------------------
package playback_pkg;

    localparam int ADDR_W_DEF = 20;
    localparam int DATA_W_DEF = 16;
    localparam int FRAC_W     = 12;
    // 17-bit diff * 3-bit k * 13-bit reciprocal fits well inside 36 bits.
    localparam int PROD_W     = 36;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FETCH_CUR  = 3'd1,
        ST_FETCH_NEXT = 3'd2,
        ST_READY      = 3'd3,
        ST_DONE       = 3'd4
    } state_e;

    // Reciprocal of N = ratio + 1 in Q12: 4096, 2048, 1365, 1024, 819, 682, 585, 512.
    function automatic logic [12:0] recip(input logic [2:0] ratio);
        logic [12:0] r;
        case (ratio)
            3'd0:    r = 13'd4096;
            3'd1:    r = 13'd2048;
            3'd2:    r = 13'd1365;
            3'd3:    r = 13'd1024;
            3'd4:    r = 13'd819;
            3'd5:    r = 13'd682;
            3'd6:    r = 13'd585;
            default: r = 13'd512;
        endcase
        return r;
    endfunction

    function automatic logic signed [15:0] sat16(input logic signed [PROD_W-1:0] v);
        logic signed [PROD_W-1:0] hi;
        logic signed [PROD_W-1:0] lo;
        logic signed [15:0]       r;
        hi = PROD_W'(32767);
        lo = -PROD_W'(32768);
        if (v > hi) begin
            r = 16'sh7FFF;
        end else if (v < lo) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/interp_unit.sv
// ---------------------------------------------------------------------------
// interp_unit
// Combinational linear interpolator between two adjacent samples.
//   cur_i   : current source sample (signed 16)
//   nxt_i   : following source sample (signed 16)
//   k_i     : phase within the slow-mode step (0..7)
//   ratio_i : speed factor select, N = ratio_i + 1
//   en_i    : 1 = interpolate, 0 = pass cur_i through unchanged
//   out_o   : cur + ((nxt - cur) * k * recip(N)) >>> 12, saturated to 16 bits
// ---------------------------------------------------------------------------
module interp_unit
    import playback_pkg::*;
(
    input  logic signed [15:0] cur_i,
    input  logic signed [15:0] nxt_i,
    input  logic        [2:0]  k_i,
    input  logic        [2:0]  ratio_i,
    input  logic               en_i,
    output logic signed [15:0] out_o
);

    logic signed [16:0]       diff;
    logic signed [PROD_W-1:0] diff_x;
    logic signed [PROD_W-1:0] k_x;
    logic signed [PROD_W-1:0] r_x;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] sum;

    always_comb begin
        // 17-bit difference cannot overflow for any pair of 16-bit samples.
        diff   = {nxt_i[15], nxt_i} - {cur_i[15], cur_i};
        diff_x = PROD_W'(diff);
        k_x    = {{(PROD_W-3){1'b0}}, k_i};
        r_x    = {{(PROD_W-13){1'b0}}, recip(ratio_i)};
        prod   = diff_x * k_x * r_x;
        // Arithmetic shift floors toward minus infinity for negative slopes.
        sum    = (prod >>> FRAC_W) + PROD_W'(cur_i);
        out_o  = en_i ? sat16(sum) : cur_i;
    end

endmodule

// File: rtl/playback_sample_engine.sv
// ---------------------------------------------------------------------------
// playback_sample_engine
// Fetches recorded samples from SRAM and emits one signed sample per
// sampleTick for the DAC serializer, with normal / fast / slow speed modes.
//
// Ports:
//   CLK50, reset              : clock and synchronous active-high reset
//   sampleTick                : one-cycle strobe per output sample period
//   start, stop               : begin playback at startAddr / abort playback
//   startAddr, endAddr        : inclusive sample address range
//   ratio                     : speed factor N = ratio + 1
//   isNormalSpeed, isSlow     : mode select (normal > slow > fast)
//   interp                    : linear interpolation in slow mode
//   pause                     : ignore ticks, hold output and position
//   sramReq/sramAddr          : read request towards the SRAM controller
//   sramData/sramValid        : read completion from the SRAM controller
//   dacSample/dacValid        : output sample and its update strobe
//   curAddr                   : address of the current source sample
//   busy, done, underrun      : status
//
// SRAM handshake: sramReq is raised in a fetch state with sramAddr stable and
// stays high until the cycle in which sramValid=1 is seen; that cycle
// completes the read and sramData is captured. A sramValid arriving while no
// request is active (e.g. after stop) is ignored.
// Note: the interpolation datapath is 16-bit; DATA_W is expected to be 16.
// ---------------------------------------------------------------------------
module playback_sample_engine
    import playback_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK50,
    input  logic              reset,
    input  logic              sampleTick,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic [ADDR_W-1:0] endAddr,
    input  logic [2:0]        ratio,
    input  logic              isNormalSpeed,
    input  logic              isSlow,
    input  logic              interp,
    input  logic              pause,
    output logic              sramReq,
    output logic [ADDR_W-1:0] sramAddr,
    input  logic [DATA_W-1:0] sramData,
    input  logic              sramValid,
    output logic [DATA_W-1:0] dacSample,
    output logic              dacValid,
    output logic [ADDR_W-1:0] curAddr,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam logic [ADDR_W:0] ADDR_ONE = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        k_q, k_d;
    logic [DATA_W-1:0] cur_q, cur_d;
    logic [DATA_W-1:0] nxt_q, nxt_d;
    logic [DATA_W-1:0] dac_q, dac_d;
    logic              dac_valid_q, dac_valid_d;
    logic              underrun_q, underrun_d;

    logic              slow_mode;
    logic              use_interp;
    logic              tick_live;
    logic [ADDR_W:0]   addr_ext;
    logic [ADDR_W:0]   end_ext;
    logic [ADDR_W:0]   addr_plus1;
    logic              next_past_end;
    logic [ADDR_W:0]   adv_addr;
    logic              advance;
    logic [DATA_W-1:0] interp_out;

    assign slow_mode     = !isNormalSpeed && isSlow;
    assign use_interp    = slow_mode && interp;
    // stop beats a tick; pause swallows it without an underrun.
    assign tick_live     = sampleTick && !pause && !stop;
    // One extra address bit so stepping past the top of SRAM never wraps.
    assign addr_ext      = {1'b0, addr_q};
    assign end_ext       = {1'b0, endAddr};
    assign addr_plus1    = addr_ext + ADDR_ONE;
    assign next_past_end = addr_plus1 > end_ext;

    interp_unit u_interp (
        .cur_i   (cur_q),
        .nxt_i   (nxt_q),
        .k_i     (k_q),
        .ratio_i (ratio),
        .en_i    (use_interp && (k_q != 3'd0)),
        .out_o   (interp_out)
    );

    always_ff @(posedge CLK50) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            k_q         <= '0;
            cur_q       <= '0;
            nxt_q       <= '0;
            dac_q       <= '0;
            dac_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            k_q         <= k_d;
            cur_q       <= cur_d;
            nxt_q       <= nxt_d;
            dac_q       <= dac_d;
            dac_valid_q <= dac_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        k_d         = k_q;
        cur_d       = cur_q;
        nxt_d       = nxt_q;
        dac_d       = dac_q;
        dac_valid_d = 1'b0;
        underrun_d  = 1'b0;
        sramReq     = 1'b0;
        sramAddr    = '0;
        adv_addr    = addr_ext;
        advance     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    addr_d  = startAddr;
                    k_d     = 3'd0;
                    state_d = ST_FETCH_CUR;
                end
            end

            ST_FETCH_CUR: begin
                sramReq  = 1'b1;
                sramAddr = addr_q;
                if (tick_live) begin
                    underrun_d = 1'b1;
                end
                if (sramValid) begin
                    cur_d   = sramData;
                    state_d = use_interp ? ST_FETCH_NEXT : ST_READY;
                end
            end

            ST_FETCH_NEXT: begin
                if (tick_live) begin
                    underrun_d = 1'b1;
                end
                if (next_past_end) begin
                    // Last sample: interpolate towards itself, no SRAM read.
                    nxt_d   = cur_q;
                    state_d = ST_READY;
                end else begin
                    sramReq  = 1'b1;
                    sramAddr = addr_plus1[ADDR_W-1:0];
                    if (sramValid) begin
                        nxt_d   = sramData;
                        state_d = ST_READY;
                    end
                end
            end

            ST_READY: begin
                if (tick_live) begin
                    dac_d       = interp_out;
                    dac_valid_d = 1'b1;
                    if (isNormalSpeed) begin
                        adv_addr = addr_plus1;
                        advance  = 1'b1;
                    end else if (!isSlow) begin
                        adv_addr = addr_ext + (ADDR_W+1)'(ratio) + ADDR_ONE;
                        advance  = 1'b1;
                    end else if (k_q >= ratio) begin
                        // Also catches k left above a newly lowered ratio.
                        adv_addr = addr_plus1;
                        advance  = 1'b1;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                    if (advance) begin
                        k_d     = 3'd0;
                        addr_d  = adv_addr[ADDR_W-1:0];
                        state_d = (adv_addr > end_ext) ? ST_DONE : ST_FETCH_CUR;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort: back to IDLE and drop any read completing this cycle.
        if (stop) begin
            state_d = ST_IDLE;
            cur_d   = cur_q;
            nxt_d   = nxt_q;
        end
    end

    assign dacSample = dac_q;
    assign dacValid  = dac_valid_q;
    assign underrun  = underrun_q;
    assign curAddr   = addr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_playback_sample_engine.sv
module tb_playback_sample_engine;
  import playback_pkg::*;

  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk;
  logic          reset;
  logic          sample_tick;
  logic          start;
  logic          stop;
  logic [AW-1:0] start_addr;
  logic [AW-1:0] end_addr;
  logic [2:0]    ratio;
  logic          is_normal;
  logic          is_slow;
  logic          interp;
  logic          pause;
  logic          sram_req;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_data;
  logic          sram_valid;
  logic [DW-1:0] dac_sample;
  logic          dac_valid;
  logic [AW-1:0] cur_addr;
  logic          busy;
  logic          done;
  logic          underrun;

  logic [DW-1:0] mem [0:511];
  int            lat;
  logic          auto_resp;
  logic          force_valid;
  logic [DW-1:0] force_data;
  int            txn_cnt;
  int            n_chk;
  int            n_pass;

  playback_sample_engine dut (
    .CLK50         (clk),
    .reset         (reset),
    .sampleTick    (sample_tick),
    .start         (start),
    .stop          (stop),
    .startAddr     (start_addr),
    .endAddr       (end_addr),
    .ratio         (ratio),
    .isNormalSpeed (is_normal),
    .isSlow        (is_slow),
    .interp        (interp),
    .pause         (pause),
    .sramReq       (sram_req),
    .sramAddr      (sram_addr),
    .sramData      (sram_data),
    .sramValid     (sram_valid),
    .dacSample     (dac_sample),
    .dacValid      (dac_valid),
    .curAddr       (cur_addr),
    .busy          (busy),
    .done          (done),
    .underrun      (underrun)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // completed SRAM reads
  initial txn_cnt = 0;
  always @(posedge clk) if (sram_req && sram_valid) txn_cnt <= txn_cnt + 1;

  // SRAM responder: valid after lat cycles of request, or forced by the test
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    sram_valid = 1'b0;
    sram_data = '0;
    forever begin
      @(negedge clk);
      #1;
      sram_valid = 1'b0;
      if (force_valid) begin
        sram_valid = 1'b1;
        sram_data = force_data;
      end else if (auto_resp && sram_req) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          sram_valid = 1'b1;
          sram_data = mem[sram_addr[8:0]];
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic check_sample(input string tag, input int e);
    logic [15:0] e16;
    e16 = 16'(e);
    check(tag, {16'h0, dac_sample}, {16'h0, e16});
  endtask

  // driver tasks: all called at a negedge, return at a negedge
  task automatic wait_state(input state_e target, input string tag);
    int n;
    n = 0;
    while (dut.state_q != target && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) check({tag, "_timeout"}, 32'(dut.state_q), 32'(target));
  endtask

  task automatic tick_pulse();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic play_tick(input string tag, input int e);
    wait_state(ST_READY, tag);
    tick_pulse();
    check({tag, "_valid"}, 32'(dac_valid), 32'd1);
    check_sample(tag, e);
  endtask

  task automatic start_play(input logic [AW-1:0] sa, input logic [AW-1:0] ea);
    start_addr = sa;
    end_addr = ea;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic stop_play();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_mode(input logic nrm, input logic slw, input logic itp, input logic [2:0] r);
    is_normal = nrm;
    is_slow = slw;
    interp = itp;
    ratio = r;
  endtask

  initial begin
    int base;
    n_chk = 0;
    n_pass = 0;
    reset = 1'b1;
    sample_tick = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    start_addr = '0;
    end_addr = '0;
    pause = 1'b0;
    lat = 2;
    auto_resp = 1'b1;
    force_valid = 1'b0;
    force_data = '0;
    set_mode(1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 512; i++) mem[i] = '0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_dac", {16'h0, dac_sample}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(sram_req), 32'd0);
    check("rst_cur_addr", 32'(cur_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // stop during FETCH_CUR with a completion in the same cycle
    auto_resp = 1'b0;
    start_play(20'h10, 20'h20);
    check("stop_req_on", 32'(sram_req), 32'd1);
    check("stop_req_addr", 32'(sram_addr), 32'h10);
    force_valid = 1'b1;
    force_data = 16'h7777;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    force_valid = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_req_off", 32'(sram_req), 32'd0);
    check("stop_cur_kept", {16'h0, dut.cur_q}, 32'd0);
    check("stop_no_done", 32'(done), 32'd0);
    auto_resp = 1'b1;
    @(negedge clk);

    // normal speed: SRAM[a] = a*10
    for (int a = 256; a < 260; a++) mem[a] = 16'(a * 10);
    base = txn_cnt;
    start_play(20'h100, 20'h103);
    play_tick("nrm0", 2560);
    play_tick("nrm1", 2570);
    play_tick("nrm2", 2580);
    play_tick("nrm3", 2590);
    check("nrm_done", 32'(done), 32'd1);
    check("nrm_txns", 32'(txn_cnt - base), 32'd4);
    @(negedge clk);
    check("nrm_idle", 32'(busy), 32'd0);

    // tick while the fetch is still outstanding
    lat = 5;
    start_play(20'h100, 20'h103);
    tick_pulse();
    check("urun_pulse", 32'(underrun), 32'd1);
    check("urun_no_valid", 32'(dac_valid), 32'd0);
    check_sample("urun_held", 2590);
    @(negedge clk);
    check("urun_one_cycle", 32'(underrun), 32'd0);
    play_tick("urun_next", 2560);
    stop_play();
    lat = 2;

    // pause: three ignored ticks
    start_play(20'h100, 20'h103);
    wait_state(ST_READY, "pause_wait");
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_pulse();
      check("pause_no_valid", 32'(dac_valid), 32'd0);
      check("pause_no_urun", 32'(underrun), 32'd0);
      check("pause_addr", 32'(cur_addr), 32'h100);
      @(negedge clk);
    end
    pause = 1'b0;
    play_tick("pause_resume", 2560);
    check("pause_adv_addr", 32'(cur_addr), 32'h101);

    // reset in READY
    wait_state(ST_READY, "rst2_wait");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst2_dac", {16'h0, dac_sample}, 32'd0);
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_cur_addr", 32'(cur_addr), 32'd0);
    check("rst2_req", 32'(sram_req), 32'd0);
    check("rst2_valid", 32'(dac_valid), 32'd0);

    // fast, ratio=2 (N=3): SRAM[i] = i
    for (int i = 0; i < 10; i++) mem[i] = 16'(i);
    set_mode(1'b0, 1'b0, 1'b0, 3'd2);
    start_play(20'h0, 20'h8);
    play_tick("fast0", 0);
    play_tick("fast1", 3);
    play_tick("fast2", 6);
    check("fast_done", 32'(done), 32'd1);
    @(negedge clk);

    // slow interp ratio=1: 100, 100 + floor(101*2048/4096)=150, 201
    mem[0] = 16'd100;
    mem[1] = 16'd201;
    mem[2] = 16'd300;
    set_mode(1'b0, 1'b1, 1'b1, 3'd1);
    start_play(20'h0, 20'h2);
    play_tick("slow_i0", 100);
    play_tick("slow_i1", 150);
    play_tick("slow_i2", 201);
    stop_play();

    // slow hold ratio=1
    set_mode(1'b0, 1'b1, 1'b0, 3'd1);
    start_play(20'h0, 20'h2);
    play_tick("slow_h0", 100);
    play_tick("slow_h1", 100);
    play_tick("slow_h2", 201);
    stop_play();

    // slow interp ratio=2: diff 300, 300*1365>>12=99, 600*1365>>12=199
    mem[0] = 16'(-300);
    mem[1] = 16'd0;
    set_mode(1'b0, 1'b1, 1'b1, 3'd2);
    start_play(20'h0, 20'h1);
    play_tick("slow3_0", -300);
    play_tick("slow3_1", -201);
    play_tick("slow3_2", -101);
    stop_play();

    // negative slope floors: -1*2048>>>12 = -1
    mem[0] = 16'd0;
    mem[1] = 16'(-1);
    set_mode(1'b0, 1'b1, 1'b1, 3'd1);
    start_play(20'h0, 20'h1);
    play_tick("neg0", 0);
    play_tick("neg1", -1);
    stop_play();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
